snn_bitmap_loader: RTL and testbench

SNN_BITMAP_LOADER -- requirements
Module: snn_bitmap_loader

---
 rtl/snn_bitmap_loader.sv | 139 +++++++++++++
 tb/tb_snn_bitmap_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_bitmap_loader.sv
// SNN bitmap loader: unpacks a 784-bit image received as 98 bytes into the
// input-unit RAM, kicks the inference core, and returns the ASCII digit.
module snn_bitmap_loader (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_rdy,
  input  logic [7:0] rx_data,
  output logic       we_input_unit,
  output logic [9:0] addr_input_unit,
  output logic       d_input_unit,
  output logic       start,
  input  logic       done,
  input  logic [3:0] digit,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    RX_WAIT,
    UNPACK,
    START,
    WAIT_DONE,
    TX
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [9:0] bit_addr;
  logic [6:0] byte_cnt;
  logic [7:0] shift_reg;
  logic [3:0] digit_reg;
  logic       result_valid;
  logic       capture;
  logic       take_result;
  logic       send;
  logic       last_bit;
  logic       frame_end;

  // Every byte starts on an 8-aligned address, so the low three address bits
  // double as the bit-within-byte count; byte 97 bit 7 is address 783.
  assign last_bit  = (bit_addr[2:0] == 3'd7);
  assign frame_end = last_bit && (byte_cnt == 7'd97);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and Moore/Mealy outputs.
  always_comb begin
    state_next    = state;
    capture       = 1'b0;
    take_result   = 1'b0;
    send          = 1'b0;
    we_input_unit = 1'b0;
    d_input_unit  = 1'b0;
    start         = 1'b0;
    tx_start      = 1'b0;
    busy          = 1'b1;
    case (state)
      IDLE, RX_WAIT: begin
        busy = 1'b0;
        if (rx_rdy) begin
          capture    = 1'b1;
          state_next = UNPACK;
        end
      end
      UNPACK: begin
        we_input_unit = 1'b1;
        d_input_unit  = shift_reg[0];
        if (last_bit) begin
          state_next = frame_end ? START : RX_WAIT;
        end
      end
      START: begin
        start      = 1'b1;
        state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (done) begin
          take_result = 1'b1;
          state_next  = TX;
        end
      end
      TX: begin
        if (!tx_busy) begin
          send       = 1'b1;
          tx_start   = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Shift register, address/byte counters and captured result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_addr     <= 10'd0;
      byte_cnt     <= 7'd0;
      shift_reg    <= 8'd0;
      digit_reg    <= 4'd0;
      result_valid <= 1'b0;
    end else begin
      if (capture) begin
        shift_reg <= rx_data;
      end
      if (state == UNPACK) begin
        shift_reg <= {1'b0, shift_reg[7:1]};
        bit_addr  <= bit_addr + 10'd1;
        if (last_bit) begin
          byte_cnt <= byte_cnt + 7'd1;
        end
      end
      if (take_result) begin
        digit_reg    <= digit;
        result_valid <= 1'b1;
      end
      if (send) begin
        bit_addr <= 10'd0;
        byte_cnt <= 7'd0;
      end
    end
  end

  assign addr_input_unit = bit_addr;
  // Result byte only changes when a new result is captured on TX entry.
  assign tx_data = result_valid ? (8'h30 + {4'h0, digit_reg}) : 8'h00;

endmodule

// File: tb/tb_snn_bitmap_loader.sv
// Self-checking bench for snn_bitmap_loader: expected RAM writes come from a
// byte-to-address model queue; frame outcomes come from a vector table.
module tb_snn_bitmap_loader;

  logic       clk;
  logic       rst_n;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic       we_input_unit;
  logic [9:0] addr_input_unit;
  logic       d_input_unit;
  logic       start;
  logic       done;
  logic [3:0] digit;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       busy;

  snn_bitmap_loader dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_rdy(rx_rdy),
    .rx_data(rx_data),
    .we_input_unit(we_input_unit),
    .addr_input_unit(addr_input_unit),
    .d_input_unit(d_input_unit),
    .start(start),
    .done(done),
    .digit(digit),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .tx_busy(tx_busy),
    .busy(busy)
  );

  typedef struct packed {
    logic [9:0] addr;
    logic       d;
  } wr_t;

  typedef struct {
    bit         ff_fill;
    logic [3:0] dig;
    int         busy_cycles;
    logic [7:0] exp_tx;
  } vec_t;

  wr_t        exp_q[$];
  int         model_addr;
  int         n_cmp;
  int         n_fail;
  int         start_count;
  int         tx_count;
  logic [7:0] tx_last;
  logic       prev783;
  vec_t       vecs[5];

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    n_cmp++;
    if (actual !== required) begin
      n_fail++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Passive monitor on the falling edge: RAM writes, start and tx_start.
  always @(negedge clk) begin
    if (rst_n) begin
      if (we_input_unit) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_write", we_input_unit, 0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          checkOutput("write_addr", addr_input_unit, e.addr);
          checkOutput("write_data", d_input_unit, e.d);
        end
      end
      if (start) begin
        start_count++;
        checkOutput("start_after_783", prev783, 1);
      end
      prev783 = we_input_unit && (addr_input_unit == 10'd783);
      if (tx_start) begin
        tx_count++;
        tx_last = tx_data;
        checkOutput("tx_start_while_busy", tx_busy, 0);
      end
    end
  end

  // Sends one byte; noise_at (0..7) pulses rx_rdy during UNPACK, which must be ignored.
  task automatic applyStimulus(input logic [7:0] b, input int noise_at);
    rx_data = b;
    rx_rdy  = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back('{addr: 10'(model_addr + k), d: b[k]});
    end
    model_addr += 8;
    tick();
    for (int i = 0; i < 8; i++) begin
      rx_rdy  = (i == noise_at);
      rx_data = 8'($urandom);
      tick();
    end
    rx_rdy = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_we"}, we_input_unit, 0);
    checkOutput({tag, "_addr"}, addr_input_unit, 0);
    checkOutput({tag, "_d"}, d_input_unit, 0);
    checkOutput({tag, "_start"}, start, 0);
    checkOutput({tag, "_tx_start"}, tx_start, 0);
    checkOutput({tag, "_tx_data"}, tx_data, 8'h00);
    checkOutput({tag, "_busy"}, busy, 0);
  endtask

  task automatic run_frame(input vec_t v);
    int sc0;
    int tc0;
    sc0 = start_count;
    tc0 = tx_count;
    checkOutput("frame_begin_addr", addr_input_unit, 0);
    for (int n = 0; n < 98; n++) begin
      applyStimulus(v.ff_fill ? 8'hFF : 8'($urandom),
                    (n == 5) ? 3 : ((n == 6) ? 7 : -1));
    end
    tick();
    checkOutput("start_pulses", start_count, sc0 + 1);
    checkOutput("writes_complete", exp_q.size(), 0);
    checkOutput("busy_wait_done", busy, 1);
    rx_rdy  = 1'b1;
    rx_data = 8'h55;
    tick();
    rx_rdy = 1'b0;
    checkOutput("addr_after_frame", addr_input_unit, 784);
    tx_busy = (v.busy_cycles > 0);
    done    = 1'b1;
    digit   = v.dig;
    tick();
    done  = 1'b0;
    digit = 4'($urandom);
    if (v.busy_cycles > 0) begin
      checkOutput("tx_data_in_tx", tx_data, v.exp_tx);
      repeat (v.busy_cycles) tick();
      checkOutput("no_tx_while_busy", tx_count, tc0);
      tx_busy = 1'b0;
    end
    tick();
    checkOutput("tx_pulses", tx_count, tc0 + 1);
    checkOutput("tx_byte", tx_last, v.exp_tx);
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_addr", addr_input_unit, 0);
    repeat (3) tick();
    checkOutput("tx_single_pulse", tx_count, tc0 + 1);
    checkOutput("tx_data_stable", tx_data, v.exp_tx);
    model_addr = 0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence.
  initial begin
    n_cmp = 0;
    n_fail = 0;
    start_count = 0;
    tx_count = 0;
    tx_last = 8'h00;
    prev783 = 1'b0;
    model_addr = 0;
    rst_n = 1'b0;
    rx_rdy = 1'b0;
    rx_data = 8'h00;
    done = 1'b0;
    digit = 4'h0;
    tx_busy = 1'b0;

    vecs[0] = '{1'b1, 4'd7, 0, 8'h37};
    vecs[1] = '{1'b0, 4'd7, 20, 8'h37};
    vecs[2] = '{1'b0, 4'd0, 0, 8'h30};
    vecs[3] = '{1'b0, 4'd9, 5, 8'h39};
    vecs[4] = '{1'b0, 4'd15, 2, 8'h3F};

    tick();
    tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;

    applyStimulus(8'hA5, -1);
    checkOutput("a5_writes_done", exp_q.size(), 0);
    checkOutput("a5_rx_wait", busy, 0);
    checkOutput("a5_addr", addr_input_unit, 8);

    done  = 1'b1;
    digit = 4'd3;
    tick();
    done = 1'b0;
    repeat (3) tick();
    checkOutput("done_ignored_tx", tx_count, 0);
    checkOutput("done_ignored_busy", busy, 0);

    for (int n = 1; n < 50; n++) begin
      applyStimulus(8'($urandom), -1);
    end
    checkOutput("partial_writes_done", exp_q.size(), 0);
    checkOutput("partial_addr", addr_input_unit, 400);
    rst_n = 1'b0;
    tick();
    check_reset_outputs("midframe_reset");
    rst_n = 1'b1;
    model_addr = 0;

    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i]);
    end

    rst_n = 1'b0;
    tick();
    check_reset_outputs("final_reset");
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
